// File: rtl/lvt_4ports_table_if.sv
// lvt_4ports_table_if: write strobes, write/read indices, last-writer selectors and busy for the 4-port LVT.
interface lvt_4ports_table_if #(
  parameter int ADDR_W = 8,
  parameter int SEL_W = 2
);
  logic we_0, we_1, we_2, we_3;
  logic [ADDR_W-1:0] waddr_0, waddr_1, waddr_2, waddr_3;
  logic [ADDR_W-1:0] raddr_0, raddr_1, raddr_2, raddr_3;
  logic [SEL_W-1:0] sel_0, sel_1, sel_2, sel_3;
  logic busy;
  modport master (
    output we_0, we_1, we_2, we_3,
    output waddr_0, waddr_1, waddr_2, waddr_3,
    output raddr_0, raddr_1, raddr_2, raddr_3,
    input sel_0, sel_1, sel_2, sel_3,
    input busy
  );
  modport slave (
    input we_0, we_1, we_2, we_3,
    input waddr_0, waddr_1, waddr_2, waddr_3,
    input raddr_0, raddr_1, raddr_2, raddr_3,
    output sel_0, sel_1, sel_2, sel_3,
    output busy
  );
endinterface

// File: rtl/lvt_4ports_table.sv
// lvt_4ports_table: live-value table recording the last writer port per address; cleared by a walk after reset.
module lvt_4ports_table #(
  parameter int ADDR_W = 8,
  parameter int SEL_W = 2
) (
  input logic clk,
  input logic reset,
  lvt_4ports_table_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [SEL_W-1:0] mem [DEPTH];
  logic [3:0] we;
  logic [3:0][ADDR_W-1:0] waddr, raddr;
  logic [3:0][SEL_W-1:0] sel;
  assign we = {bus.we_3, bus.we_2, bus.we_1, bus.we_0};
  assign waddr = {bus.waddr_3, bus.waddr_2, bus.waddr_1, bus.waddr_0};
  assign raddr = {bus.raddr_3, bus.raddr_2, bus.raddr_1, bus.raddr_0};
  assign bus.sel_0 = sel[0];
  assign bus.sel_1 = sel[1];
  assign bus.sel_2 = sel[2];
  assign bus.sel_3 = sel[3];
  assign bus.busy = state == CLEAR;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : clr_cnt;
    end
  end
  always_comb begin
    state_nxt = state;
    state_nxt = (state == CLEAR && &clr_cnt) ? READY : state_nxt;
  end
  always_ff @(posedge clk)
    for (int k = 0; k < 4; k++) sel[k] <= (reset || state == CLEAR) ? '0 : mem[raddr[k]];
  // No reset on the array so it can map to RAM; later ports override earlier ones on a collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) mem[clr_cnt] <= '0;
      else for (int k = 0; k < 4; k++) if (we[k]) mem[waddr[k]] <= SEL_W'(k);
    end
  end
endmodule

// File: tb/tb_lvt_4ports_table.sv
// tb_lvt_4ports_table: randomized and directed stimulus against a last-writer array model with a queued scoreboard.
module tb_lvt_4ports_table;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  lvt_4ports_table_if #(.ADDR_W(8), .SEL_W(2)) bus ();
  lvt_4ports_table #(.ADDR_W(8), .SEL_W(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  typedef struct packed {
    logic busy;
    logic [3:0][1:0] sel;
  } exp_t;
  exp_t q[$];
  int mem_m[256];
  int clr_left = 256;
  int checks = 0;
  int passes = 0;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask
  task automatic step(input logic r, input logic [3:0] we, input logic [3:0][7:0] wa, input logic [3:0][7:0] ra);
    exp_t e;
    @(negedge clk);
    reset = r;
    {bus.we_3, bus.we_2, bus.we_1, bus.we_0} = we;
    {bus.waddr_3, bus.waddr_2, bus.waddr_1, bus.waddr_0} = wa;
    {bus.raddr_3, bus.raddr_2, bus.raddr_1, bus.raddr_0} = ra;
    e = '0;
    if (r) begin
      clr_left = 256;
      e.busy = 1;
    end else if (clr_left > 0) begin
      mem_m[256 - clr_left] = 0;
      clr_left--;
      e.busy = clr_left > 0;
    end else begin
      for (int k = 0; k < 4; k++) e.sel[k] = 2'(mem_m[ra[k]]);
      for (int k = 0; k < 4; k++) if (we[k]) mem_m[wa[k]] = k;
    end
    q.push_back(e);
  endtask
  task automatic rnd_step(input logic r, input int span);
    logic [3:0][7:0] wa, ra;
    for (int k = 0; k < 4; k++) begin
      wa[k] = 8'($urandom_range(0, span));
      ra[k] = 8'($urandom_range(0, span));
    end
    step(r, 4'($urandom), wa, ra);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("busy", {7'd0, bus.busy}, {7'd0, e.busy});
        chk("sel_0", {6'd0, bus.sel_0}, {6'd0, e.sel[0]});
        chk("sel_1", {6'd0, bus.sel_1}, {6'd0, e.sel[1]});
        chk("sel_2", {6'd0, bus.sel_2}, {6'd0, e.sel[2]});
        chk("sel_3", {6'd0, bus.sel_3}, {6'd0, e.sel[3]});
      end
    end
  end
  initial begin
    int guard;
    step(1, 4'b0, '0, '0);
    for (int i = 0; i < 256; i++) rnd_step(0, 255);
    for (int i = 0; i < 64; i++) step(0, 4'b0, '0, {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)});
    step(0, 4'b0100, {8'h00, 8'h15, 8'h00, 8'h00}, '0);
    step(0, 4'b0000, '0, {8'h16, 8'h00, 8'h00, 8'h15});
    step(0, 4'b1010, {8'h40, 8'h00, 8'h40, 8'h00}, '0);
    step(0, 4'b0000, '0, {8'h40, 8'h40, 8'h40, 8'h40});
    step(0, 4'b0010, {8'h00, 8'h00, 8'h07, 8'h00}, '0);
    step(0, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h07}, {8'h00, 8'h07, 8'h00, 8'h00});
    step(0, 4'b0000, '0, {8'h00, 8'h07, 8'h00, 8'h00});
    step(0, 4'b1111, {8'h04, 8'h03, 8'h02, 8'h01}, '0);
    step(0, 4'b0000, '0, {8'h04, 8'h03, 8'h02, 8'h01});
    for (int i = 0; i < 1500; i++) rnd_step(0, (i % 3 == 0) ? 255 : 15);
    step(1, 4'b0, '0, '0);
    for (int i = 0; i < 100; i++) rnd_step(0, 15);
    step(1, 4'b1111, {8'h05, 8'h06, 8'h07, 8'h08}, '0);
    for (int i = 0; i < 256; i++) rnd_step(0, 15);
    for (int i = 0; i < 40; i++) step(0, 4'b0, '0, {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))});
    for (int i = 0; i < 500; i++) rnd_step(0, 31);
    step(0, 4'b0, '0, '0);
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    chk("drain", 8'(q.size()), 8'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
